// File: rtl/reg_file_param_if.sv
// Register file bus: read ports, write port, scoreboard reserve and init status.
// Ports: read_reg1/2 -> read_data1/2 + read_busy1/2; reg_write/write_reg/write_data;
//        reserve/reserve_reg; init_done. master = datapath control, slave = register file.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              init_done;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              read_busy1;
  logic              read_busy2;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reserve;
  logic [ADDR_W-1:0] reserve_reg;

  modport master (
    input  init_done, read_data1, read_data2, read_busy1, read_busy2,
    output read_reg1, read_reg2, reg_write, write_reg, write_data, reserve, reserve_reg
  );

  modport slave (
    output init_done, read_data1, read_data2, read_busy1, read_busy2,
    input  read_reg1, read_reg2, reg_write, write_reg, write_data, reserve, reserve_reg
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file (2 async read ports, 1 sync write port) with a
// hardware clear sequencer after reset and a per-register pending-write scoreboard.
// Ports: clk, rst_n (async active-low), rf (reg_file_param_if.slave).
// Optional: define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_file_param_if.slave      rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run;
  logic              wr_ok;
  logic              rsv_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign run    = (state_q == RUN);
  // Register 0 is never written and never reserved; requests during INIT are dropped.
  assign wr_ok  = run && rf.reg_write && (rf.write_reg != '0);
  assign rsv_ok = run && rf.reserve && (rf.reserve_reg != '0);

  assign rf.init_done = run;

  // Next-state: clear sequencer in INIT, write/reserve scoreboard in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_waddr = rf.write_reg;
    mem_wdata = rf.write_data;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        mem_we = wr_ok;
        if (wr_ok)  busy_d[rf.write_reg]   = 1'b0;
        // Applied after the write clear: a same-register reserve is the newer producer.
        if (rsv_ok) busy_d[rf.reserve_reg] = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage has no reset; the clear sequencer zeroes it. Held off while rst_n is low.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem_q[mem_waddr] <= mem_wdata;
  end

  // Read port 1
  always_comb begin
    rf.read_data1 = '0;
    rf.read_busy1 = 1'b0;
    if (run && (rf.read_reg1 != '0)) begin
      rf.read_data1 = mem_q[rf.read_reg1];
      rf.read_busy1 = busy_q[rf.read_reg1];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (rf.write_reg == rf.read_reg1)) begin
        rf.read_data1 = rf.write_data;
        rf.read_busy1 = rsv_ok && (rf.reserve_reg == rf.read_reg1);
      end
`endif
    end
  end

  // Read port 2
  always_comb begin
    rf.read_data2 = '0;
    rf.read_busy2 = 1'b0;
    if (run && (rf.read_reg2 != '0)) begin
      rf.read_data2 = mem_q[rf.read_reg2];
      rf.read_busy2 = busy_q[rf.read_reg2];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (rf.write_reg == rf.read_reg2)) begin
        rf.read_data2 = rf.write_data;
        rf.read_busy2 = rsv_ok && (rf.reserve_reg == rf.read_reg2);
      end
`endif
    end
  end
endmodule

// File: tb/tb_reg_file_param.sv
// Directed testbench for reg_file_param: reset/clear sequence, read/write,
// register zero, scoreboard, INIT blocking and same-cycle read-during-write.
module tb_reg_file_param;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) rf ();

  reg_file_param #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one posedge and settle 2ns after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rf.reg_write   = 1'b0;
    rf.write_reg   = '0;
    rf.write_data  = '0;
    rf.reserve     = 1'b0;
    rf.reserve_reg = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    rf.read_reg1 = 5'd3;
    rf.read_reg2 = 5'd3;

    // Reset state
    #12;
    check("rst_init_done", {31'd0, rf.init_done}, 32'd0);
    check("rst_busy1", {31'd0, rf.read_busy1}, 32'd0);

    // INIT blocking: write+reserve r3 held during the whole clear sequence
    rf.reg_write   = 1'b1;
    rf.write_reg   = 5'd3;
    rf.write_data  = 32'hDEAD_BEEF;
    rf.reserve     = 1'b1;
    rf.reserve_reg = 5'd3;
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    check("init_done_31", {31'd0, rf.init_done}, 32'd0);
    check("init_rdata_zero", rf.read_data1, 32'd0);
    tick();
    check("init_done_32", {31'd0, rf.init_done}, 32'd1);
    idle();
    #1;
    check("init_block_r3", rf.read_data1, 32'd0);
    check("init_block_busy3", {31'd0, rf.read_busy1}, 32'd0);

    // Basic write/read
    rf.read_reg1  = 5'd1;
    rf.read_reg2  = 5'd30;
    rf.reg_write  = 1'b1;
    rf.write_reg  = 5'd1;
    rf.write_data = 32'h0000_FFFF;
    #1;
    check("r1_same_cycle", rf.read_data1, BYP ? 32'h0000_FFFF : 32'd0);
    tick();
    rf.write_reg  = 5'd30;
    rf.write_data = 32'hFFFF_0000;
    #1;
    check("r1_after", rf.read_data1, 32'h0000_FFFF);
    check("r30_same_cycle", rf.read_data2, BYP ? 32'hFFFF_0000 : 32'd0);
    tick();
    idle();
    #1;
    check("r30_after", rf.read_data2, 32'hFFFF_0000);

    // Register zero: write and reserve are discarded
    rf.read_reg1   = 5'd0;
    rf.read_reg2   = 5'd1;
    rf.reg_write   = 1'b1;
    rf.write_reg   = 5'd0;
    rf.write_data  = 32'h1234_5678;
    rf.reserve     = 1'b1;
    rf.reserve_reg = 5'd0;
    tick();
    idle();
    #1;
    check("r0_data", rf.read_data1, 32'd0);
    check("r0_busy", {31'd0, rf.read_busy1}, 32'd0);
    check("r1_untouched", rf.read_data2, 32'h0000_FFFF);

    // Scoreboard
    rf.read_reg1   = 5'd7;
    rf.read_reg2   = 5'd8;
    rf.reserve     = 1'b1;
    rf.reserve_reg = 5'd7;
    #1;
    check("r7_busy_before", {31'd0, rf.read_busy1}, 32'd0);
    tick();
    idle();
    #1;
    check("r7_busy_set", {31'd0, rf.read_busy1}, 32'd1);
    rf.reg_write  = 1'b1;
    rf.write_reg  = 5'd7;
    rf.write_data = 32'h5A5A_5A5A;
    #1;
    check("r7_busy_wr_cycle", {31'd0, rf.read_busy1}, BYP ? 32'd0 : 32'd1);
    tick();
    idle();
    #1;
    check("r7_busy_cleared", {31'd0, rf.read_busy1}, 32'd0);
    check("r7_data", rf.read_data1, 32'h5A5A_5A5A);
    rf.reg_write   = 1'b1;
    rf.write_reg   = 5'd7;
    rf.write_data  = 32'hA5A5_A5A5;
    rf.reserve     = 1'b1;
    rf.reserve_reg = 5'd7;
    tick();
    idle();
    #1;
    check("r7_rsv_wr_data", rf.read_data1, 32'hA5A5_A5A5);
    check("r7_rsv_wr_busy", {31'd0, rf.read_busy1}, 32'd1);
    // Different registers in one cycle: write r7 clears, reserve r8 sets
    rf.reg_write   = 1'b1;
    rf.write_reg   = 5'd7;
    rf.write_data  = 32'h0F0F_0F0F;
    rf.reserve     = 1'b1;
    rf.reserve_reg = 5'd8;
    tick();
    idle();
    #1;
    check("r7_busy_split", {31'd0, rf.read_busy1}, 32'd0);
    check("r8_busy_split", {31'd0, rf.read_busy2}, 32'd1);
    check("r7_data_split", rf.read_data1, 32'h0F0F_0F0F);

    // Read-during-write of r9
    rf.read_reg1  = 5'd9;
    rf.reg_write  = 1'b1;
    rf.write_reg  = 5'd9;
    rf.write_data = 32'hCAFE_F00D;
    #1;
    check("r9_same_cycle", rf.read_data1, BYP ? 32'hCAFE_F00D : 32'd0);
    tick();
    idle();
    #1;
    check("r9_after", rf.read_data1, 32'hCAFE_F00D);

    // Reset clear mid-operation
    rf.read_reg1  = 5'd5;
    rf.reg_write  = 1'b1;
    rf.write_reg  = 5'd5;
    rf.write_data = 32'hFFFF_FFFF;
    tick();
    idle();
    #1;
    check("r5_written", rf.read_data1, 32'hFFFF_FFFF);
    check("r8_busy_pre_rst", {31'd0, rf.read_busy2}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_init_done", {31'd0, rf.init_done}, 32'd0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    check("reinit_done_31", {31'd0, rf.init_done}, 32'd0);
    tick();
    check("reinit_done_32", {31'd0, rf.init_done}, 32'd1);
    check("r5_cleared", rf.read_data1, 32'd0);
    check("r8_busy_cleared", {31'd0, rf.read_busy2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
